mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the operand/result width in bits.
REQ-002 Parameter VEC_LEN, default 784, SHALL set the operand pairs per dot product (range 1..2^ADDR_WIDTH).
REQ-003 Parameter ADDR_WIDTH, default 10, SHALL set the read-address width.
REQ-004 Parameter MULT_LATENCY, default 1, SHALL set the cycles from operands at the element inputs to the product entering its accumulator.
REQ-005 The design SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin one dot product
- busy  out  1  high in any state other than IDLE
- rd_en  out  1  operand memory read strobe
- rd_addr  out  ADDR_WIDTH  operand pair index
- rd_a  in  DATA_WIDTH  signed activation; valid one cycle after rd_en
- rd_b  in  DATA_WIDTH  signed weight; valid one cycle after rd_en
- mac_clear  out  1  drives the accumulator element's synchronous clear
- mac_a  out  DATA_WIDTH  signed operand to element
- mac_b  out  DATA_WIDTH  signed operand to element
- mac_out  in  DATA_WIDTH  element accumulator value
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_WIDTH  captured dot product

Function
REQ-007 The FSM SHALL have states IDLE, FEED, DRAIN and HOLD.
REQ-008 IDLE: mac_clear=1, mac_a=mac_b=0; start=1 -> FEED on the next edge.
REQ-009 FEED SHALL last exactly VEC_LEN cycles, with rd_en=1 and rd_addr=0,1,...,VEC_LEN-1, one per cycle; after the last address -> DRAIN.
REQ-010 mac_clear SHALL be 0 in FEED, DRAIN and HOLD.
REQ-011 mac_a/mac_b SHALL be registered: rd_a/rd_b when rd_en was high in the previous cycle, else 0.
- Because the element accumulates every cycle, it never sees non-zero operands outside valid pairs.
REQ-012 DRAIN SHALL last exactly MULT_LATENCY+3 cycles, counted by an internal counter.
- On the edge ending the last DRAIN cycle, res_data <= mac_out, res_valid <= 1, state -> HOLD.
REQ-013 HOLD: res_valid=1 and res_data stable until res_valid && res_ready at an edge; then res_valid <= 0 and state -> IDLE.
REQ-014 res_valid SHALL first assert exactly VEC_LEN+MULT_LATENCY+4 cycles after the edge that sampled start.
REQ-015 start SHALL be ignored in FEED, DRAIN and HOLD, including start coincident with the HOLD handshake; no queuing.
REQ-016 res_ready SHALL be ignored outside HOLD.
REQ-017 res_data SHALL be mac_out unmodified; two's-complement wrap in the element is passed through, with no saturation.
REQ-018 The FEED address counter SHALL not wrap; rd_addr SHALL return to 0 in all non-FEED states.

Reset
REQ-019 reset=0 SHALL asynchronously force state=IDLE, busy=0, rd_en=0, rd_addr=0, mac_a=mac_b=0, mac_clear=1, res_valid=0, res_data=0, and the drain counter to 0.
REQ-020 Reset asserted mid-FEED/DRAIN/HOLD SHALL discard the operation.
- After release, no res_valid until a new start completes.

Verification
REQ-021 VEC_LEN=4, MULT_LATENCY=1, a={1,2,3,4}, b={5,6,7,8}, res_ready=1: start pulse -> res_valid asserts 9 cycles later with res_data=70, then busy=0 one cycle after the handshake.
REQ-022 a={-3,2,-1,4}, b={7,-5,6,2}: start pulse -> res_data=-29 (0xFFE3).
REQ-023 Hold res_ready=0 for 10 cycles in HOLD -> res_valid and res_data stable for those 10 cycles, mac_out unchanged; res_ready=1 -> IDLE next cycle.
REQ-024 Pulse start on every cycle of FEED, DRAIN and HOLD -> exactly one result, rd_addr sequence 0..3 issued once.
REQ-025 Assert reset on the 2nd FEED cycle, release, start again with the REQ-021 data -> res_data=70, not corrupted by the aborted partial sum.
REQ-026 a=b={32767 x4} -> res_data equals the element's wrapped 16-bit sum, bit-exact against a model.

Source files
------------

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams VEC_LEN operand pairs from an operand memory into an
// external accumulating MAC element, then captures the element's sum behind a valid/ready handshake.
module mac_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int VEC_LEN      = 784,
  parameter int ADDR_WIDTH   = 10,
  parameter int MULT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_a,
  input  logic [DATA_WIDTH-1:0] rd_b,
  output logic                  mac_clear,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [DATA_WIDTH-1:0] mac_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data
);

  // The last pair needs: memory read (1) + operand register (1) + multiplier
  // (MULT_LATENCY) + accumulate (1) before mac_out holds the complete sum.
  localparam int DRAIN_CYCLES = MULT_LATENCY + 3;
  localparam int CNT_WIDTH    = $clog2(DRAIN_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(VEC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_DRAIN = CNT_WIDTH'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [CNT_WIDTH-1:0]  r_drain_cnt;
  logic                  r_rd_en_d;
  logic [DATA_WIDTH-1:0] r_mac_a;
  logic [DATA_WIDTH-1:0] r_mac_b;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;

  assign busy      = (r_state != ST_IDLE);
  assign rd_en     = (r_state == ST_FEED);
  assign mac_clear = (r_state == ST_IDLE);
  assign rd_addr   = r_rd_addr;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  // The element accumulates every cycle, so operands are forced to zero
  // except in the cycle where the read data for a strobed address is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_en_d <= 1'b0;
      r_mac_a   <= '0;
      r_mac_b   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_rd_en_d <= rd_en;
      r_mac_a   <= r_rd_en_d ? rd_a : '0;
      r_mac_b   <= r_rd_en_d ? rd_b : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rd_addr   <= '0;
      r_drain_cnt <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_FEED;
            r_rd_addr <= '0;
          end
        end
        ST_FEED: begin
          if (r_rd_addr == LAST_ADDR) begin
            r_state     <= ST_DRAIN;
            r_rd_addr   <= '0;
            r_drain_cnt <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == LAST_DRAIN) begin
            r_state     <= ST_HOLD;
            r_drain_cnt <= '0;
            r_res_data  <= mac_out;
            r_res_valid <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a registered operand memory and an
// accumulating MAC element (one-cycle multiplier) modelled around it.
module tb_mac_sequencer;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int VL = 4;
  localparam int ML = 1;
  localparam int EXP_LAT = VL + ML + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_a = '0;
  logic [DW-1:0] rd_b = '0;
  logic          mac_clear;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [DW-1:0] mac_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] mem_a [VL];
  logic [DW-1:0] mem_b [VL];
  logic [AW-1:0] addr_q [$];
  int            n_hs = 0;

  logic signed [DW-1:0] elem_prod = '0;
  logic signed [DW-1:0] elem_acc  = '0;

  mac_sequencer #(
    .DATA_WIDTH  (DW),
    .VEC_LEN     (VL),
    .ADDR_WIDTH  (AW),
    .MULT_LATENCY(ML)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .mac_clear(mac_clear),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_out  (mac_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data)
  );

  always #5 clk = ~clk;

  // Operand memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr[1:0]];
      rd_b <= mem_b[rd_addr[1:0]];
    end else begin
      rd_a <= 16'h5A5A;
      rd_b <= 16'hA5A5;
    end
  end

  // MAC element: one product register, then a wrapping accumulator with synchronous clear.
  always @(posedge clk) begin
    elem_prod <= DW'($signed(mac_a) * $signed(mac_b));
    if (mac_clear) elem_acc <= '0;
    else           elem_acc <= elem_acc + elem_prod;
  end
  assign mac_out = elem_acc;

  always @(posedge clk) begin
    if (rd_en) addr_q.push_back(rd_addr);
    if (res_valid && res_ready) n_hs++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3);
    mem_a[0] = DW'(a0); mem_a[1] = DW'(a1); mem_a[2] = DW'(a2); mem_a[3] = DW'(a3);
    mem_b[0] = DW'(b0); mem_b[1] = DW'(b1); mem_b[2] = DW'(b2); mem_b[3] = DW'(b3);
  endtask

  function automatic logic [DW-1:0] model_dot();
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < VL; i++) acc = acc + DW'($signed(mem_a[i]) * $signed(mem_b[i]));
    return acc;
  endfunction

  // Leaves the bench at the negedge of the first cycle after start was sampled.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles (current negedge = 1) until res_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_addrs(input string tag, input int base);
    check({tag, "_naddr"}, addr_q.size() - base, VL);
    for (int i = 0; i < VL; i++)
      check($sformatf("%s_addr%0d", tag, i),
            (base + i < addr_q.size()) ? 32'(addr_q[base + i]) : 32'hFFFF_FFFF, i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int hs0;
    logic seen;

    reset = 1'b0;
    start = 1'b0;
    res_ready = 1'b1;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_mac_clear", mac_clear, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic dot product with ready always high.
    load(1, 2, 3, 4, 5, 6, 7, 8);
    base = addr_q.size();
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_rd_en", rd_en, 1);
    check("t1_first_addr", rd_addr, 0);
    check("t1_clear", mac_clear, 0);
    wait_result(lat);
    check("t1_latency", lat, EXP_LAT);
    check("t1_data", res_data, 70);
    check("t1_busy_hold", busy, 1);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", res_valid, 0);
    check("t1_addr_idle", rd_addr, 0);
    check_addrs("t1", base);

    // Mixed-sign operands.
    load(-3, 2, -1, 4, 7, -5, 6, 2);
    pulse_start();
    wait_result(lat);
    check("t2_latency", lat, EXP_LAT);
    check("t2_data", res_data, 16'hFFE3);
    @(negedge clk);

    // Back-pressure in HOLD.
    load(1, 2, 3, 4, 5, 6, 7, 8);
    res_ready = 1'b0;
    pulse_start();
    wait_result(lat);
    check("t3_latency", lat, EXP_LAT);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_valid_c%0d", i), res_valid, 1);
      check($sformatf("t3_data_c%0d", i), res_data, 70);
      check($sformatf("t3_macout_c%0d", i), mac_out, 70);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_released", res_valid, 0);
    check("t3_busy_released", busy, 0);

    // start held high through FEED, DRAIN, HOLD and the handshake edge.
    res_ready = 1'b0;
    base = addr_q.size();
    hs0 = n_hs;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_result(lat);
    check("t4_latency", lat, EXP_LAT);
    repeat (3) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_after_hs", busy, 0);
    repeat (12) @(negedge clk);
    check("t4_results", n_hs - hs0, 1);
    check("t4_busy_end", busy, 0);
    check("t4_data", res_data, 70);
    check_addrs("t4", base);

    // Reset on the second FEED cycle, then a clean rerun.
    pulse_start();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_rd_en", rd_en, 0);
    check("t5_async_clear", mac_clear, 1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("t5_no_stale_valid", seen, 0);
    pulse_start();
    wait_result(lat);
    check("t5_latency", lat, EXP_LAT);
    check("t5_data", res_data, 70);
    @(negedge clk);

    // Overflow wraps in the element and passes through untouched.
    load(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
    pulse_start();
    wait_result(lat);
    check("t6_latency", lat, EXP_LAT);
    check("t6_data", res_data, model_dot());
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
